// File: rtl/dpram_port_arbiter.sv
// Two-channel valid/ready arbiter and sequencer in front of an 8x8 dual-port RAM.
// Optional collision counter built when COLLISION_COUNT_EN is defined.
module dpram_port_arbiter #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a_valid,
  output logic          req_a_ready,
  input  logic          req_a_we,
  input  logic [AW-1:0] req_a_addr,
  input  logic [DW-1:0] req_a_wdata,
  output logic          rsp_a_valid,
  output logic [DW-1:0] rsp_a_rdata,
  input  logic          req_b_valid,
  output logic          req_b_ready,
  input  logic          req_b_we,
  input  logic [AW-1:0] req_b_addr,
  input  logic [DW-1:0] req_b_wdata,
  output logic          rsp_b_valid,
  output logic [DW-1:0] rsp_b_rdata,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic          wra,
  output logic          wrb,
  output logic          rda,
  output logic          rdb,
  output logic [AW-1:0] addrs_a,
  output logic [AW-1:0] addrs_b,
  input  logic [DW-1:0] out_a,
  input  logic [DW-1:0] out_b,
  output logic [15:0]   coll_cnt
);

  logic          conflict, acc_a, acc_b;
  logic          prio_q, prio_d;
  logic          wra_q, wra_d, rda_q, rda_d, wrb_q, wrb_d, rdb_q, rdb_d;
  logic [AW-1:0] addrs_a_q, addrs_a_d, addrs_b_q, addrs_b_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          rd_pend_a_q, rd_pend_a_d, rd_pend_b_q, rd_pend_b_d;
  logic          rsp_a_valid_q, rsp_a_valid_d, rsp_b_valid_q, rsp_b_valid_d;
  logic [DW-1:0] rsp_a_rdata_q, rsp_a_rdata_d, rsp_b_rdata_q, rsp_b_rdata_d;

  assign conflict = req_a_valid & req_b_valid & (req_a_addr == req_b_addr) &
                    (req_a_we | req_b_we);

  // Under conflict only the prioritised channel is ready; the loser wins next time.
  assign req_a_ready = ~rst & (~conflict | ~prio_q);
  assign req_b_ready = ~rst & (~conflict | prio_q);
  assign acc_a = req_a_valid & req_a_ready;
  assign acc_b = req_b_valid & req_b_ready;

  always_comb begin
    prio_d        = conflict ? ~prio_q : prio_q;
    wra_d         = acc_a & req_a_we;
    rda_d         = acc_a & ~req_a_we;
    wrb_d         = acc_b & req_b_we;
    rdb_d         = acc_b & ~req_b_we;
    addrs_a_d     = acc_a ? req_a_addr : addrs_a_q;
    addrs_b_d     = acc_b ? req_b_addr : addrs_b_q;
    a_d           = acc_a ? req_a_wdata : a_q;
    b_d           = acc_b ? req_b_wdata : b_q;
    // RAM samples the read at the edge after issue; data is captured one edge later.
    rd_pend_a_d   = rda_q;
    rd_pend_b_d   = rdb_q;
    rsp_a_valid_d = rd_pend_a_q;
    rsp_b_valid_d = rd_pend_b_q;
    rsp_a_rdata_d = rd_pend_a_q ? out_a : rsp_a_rdata_q;
    rsp_b_rdata_d = rd_pend_b_q ? out_b : rsp_b_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q        <= 1'b0;
      wra_q         <= 1'b0;
      rda_q         <= 1'b0;
      wrb_q         <= 1'b0;
      rdb_q         <= 1'b0;
      addrs_a_q     <= '0;
      addrs_b_q     <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rd_pend_a_q   <= 1'b0;
      rd_pend_b_q   <= 1'b0;
      rsp_a_valid_q <= 1'b0;
      rsp_b_valid_q <= 1'b0;
      rsp_a_rdata_q <= '0;
      rsp_b_rdata_q <= '0;
    end else begin
      prio_q        <= prio_d;
      wra_q         <= wra_d;
      rda_q         <= rda_d;
      wrb_q         <= wrb_d;
      rdb_q         <= rdb_d;
      addrs_a_q     <= addrs_a_d;
      addrs_b_q     <= addrs_b_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rd_pend_a_q   <= rd_pend_a_d;
      rd_pend_b_q   <= rd_pend_b_d;
      rsp_a_valid_q <= rsp_a_valid_d;
      rsp_b_valid_q <= rsp_b_valid_d;
      rsp_a_rdata_q <= rsp_a_rdata_d;
      rsp_b_rdata_q <= rsp_b_rdata_d;
    end
  end

`ifdef COLLISION_COUNT_EN
  logic [15:0] coll_cnt_q, coll_cnt_d;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (conflict && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_cnt_q <= 16'h0000;
    else     coll_cnt_q <= coll_cnt_d;
  end

  assign coll_cnt = coll_cnt_q;
`else
  assign coll_cnt = 16'h0000;
`endif

  assign wra         = wra_q;
  assign rda         = rda_q;
  assign wrb         = wrb_q;
  assign rdb         = rdb_q;
  assign addrs_a     = addrs_a_q;
  assign addrs_b     = addrs_b_q;
  assign a           = a_q;
  assign b           = b_q;
  assign rsp_a_valid = rsp_a_valid_q;
  assign rsp_b_valid = rsp_b_valid_q;
  assign rsp_a_rdata = rsp_a_rdata_q;
  assign rsp_b_rdata = rsp_b_rdata_q;

endmodule
